// File: rtl/piso_shifter_if.sv
// Handshake/data bundle for piso_shifter: load request, shift enable and parallel word in,
// ready/serial bit/valid/done out. The master drives the requests; the shifter is the slave.
interface piso_shifter_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic             en;
  logic [WIDTH-1:0] in;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             done;

  modport master (
    output load, en, in,
    input  ready, sout, sout_valid, done
  );

  modport slave (
    input  load, en, in,
    output ready, sout, sout_valid, done
  );
endinterface

// File: rtl/piso_shifter.sv
// Parallel-in serial-out shifter: captures a word on load while ready, emits one bit per enabled
// clock, then pulses done. Define PISO_PARITY_EN to append an even-parity bit after the data.
//
// Handshake: load is accepted only at an edge where ready=1; it is never queued. sout is
// meaningful only while sout_valid=1 and is forced to 0 otherwise. en=0 stalls the current
// bit (data or parity); done is a one-cycle pulse that en does not gate. All outputs are registered.
module piso_shifter #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                clk,
  input  logic                reset,
  piso_shifter_if.slave       bus,
  output logic [1:0]          dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2, S_PARITY = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             sout_q, sout_d;
  logic             sout_valid_q, sout_valid_d;
  logic             done_q, done_d;
  logic             cur_bit;
`ifdef PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      sout_q       <= 1'b0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
`ifdef PISO_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          state_d = S_SHIFT;
          shreg_d = bus.in;
          cnt_d   = '0;
`ifdef PISO_PARITY_EN
          parity_d = ^bus.in;
`endif
        end
      end
      S_SHIFT: begin
        if (bus.en) begin
          // The next bit to send always sits at the outgoing end of the register.
          shreg_d = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
          if (cnt_q == LAST_IDX) begin
            cnt_d = CW'(WIDTH);
`ifdef PISO_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (bus.en) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in the cycle they describe.
  always_comb begin
    cur_bit      = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
    ready_d      = (state_d == S_IDLE);
    done_d       = (state_d == S_DONE);
    sout_valid_d = 1'b0;
    sout_d       = 1'b0;
    if (state_d == S_SHIFT) begin
      sout_valid_d = 1'b1;
      sout_d       = cur_bit;
    end
`ifdef PISO_PARITY_EN
    if (state_d == S_PARITY) begin
      sout_valid_d = 1'b1;
      sout_d       = parity_d;
    end
`endif
  end

  assign bus.ready      = ready_q;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.done       = done_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_piso_shifter.sv
// Directed bench for piso_shifter: one MSB-first and one LSB-first instance share the same stimulus.
// Honours PISO_PARITY_EN (expects the extra parity slot when defined).
module tb_piso_shifter;

`ifdef PISO_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic       clk;
  logic       rst;
  logic       load;
  logic       en;
  logic [7:0] din;
  logic [1:0] dbg_m, dbg_l;
  int         n_assert;
  int         n_fail;

  piso_shifter_if #(.WIDTH(8)) if_m ();
  piso_shifter_if #(.WIDTH(8)) if_l ();

  assign if_m.load = load;
  assign if_m.en   = en;
  assign if_m.in   = din;
  assign if_l.load = load;
  assign if_l.en   = en;
  assign if_l.in   = din;

  piso_shifter #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(rst), .bus(if_m), .dbg_state_o(dbg_m)
  );
  piso_shifter #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(rst), .bus(if_l), .dbg_state_o(dbg_l)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected vector {ready, sout_valid, sout, done} for each instance.
  task automatic chk_out(input string tag, input logic rdy, input logic vld,
                         input logic sm, input logic sl, input logic dn);
    chk({tag, "/msb"}, {4'b0, if_m.ready, if_m.sout_valid, if_m.sout, if_m.done},
        {4'b0, rdy, vld, sm, dn});
    chk({tag, "/lsb"}, {4'b0, if_l.ready, if_l.sout_valid, if_l.sout, if_l.done},
        {4'b0, rdy, vld, sl, dn});
  endtask

  // Full transfer of w; optional stall of stall_n cycles starting at cycle stall_at,
  // and an ignored load of 8'hFF presented at cycle ld_at.
  task automatic xfer(input string tag, input logic [7:0] w, input int stall_at,
                      input int stall_n, input int ld_at);
    din  = w;
    load = 1'b1;
    en   = 1'b1;
    tick();
    load = 1'b0;
    din  = ~w;
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("%s bit%0d", tag, i), 1'b0, 1'b1, w[7-i], w[i], 1'b0);
      if (i + 1 == stall_at) begin
        en = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk_out($sformatf("%s hold%0d", tag, s), 1'b0, 1'b1, w[7-i], w[i], 1'b0);
        end
        en = 1'b1;
      end
      if (i + 1 == ld_at) begin
        load = 1'b1;
        din  = 8'hFF;
      end
      tick();
      load = 1'b0;
    end
    if (PAR == 1) begin
      chk_out({tag, " parity"}, 1'b0, 1'b1, ^w, ^w, 1'b0);
      tick();
    end
    chk_out({tag, " done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out({tag, " ready"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst  = 1'b1;
    load = 1'b0;
    en   = 1'b0;
    din  = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset state", {6'b0, dbg_m}, 8'd0);

    // en ignored while idle
    en = 1'b1;
    tick();
    chk_out("idle en", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // basic stream 10110010, back-to-back with a second word
    xfer("basic", 8'b10110010, 0, 0, 0);
    xfer("basic2", 8'b00000111, 0, 0, 0);

    // stall during cycles 4-6
    tick();
    xfer("stall", 8'b10110010, 4, 3, 0);

    // load of 8'hFF on cycle 3 is ignored
    tick();
    xfer("ignload", 8'b10110010, 0, 0, 3);
    tick();
    chk_out("no 2nd done", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // stall on the last data bit, then all-ones word
    xfer("stall last", 8'b11111111, 8, 2, 0);
    xfer("ones-x", 8'b01111110, 1, 1, 0);

    // reset mid-transfer at edge 5
    din  = 8'b10110010;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    chk_out("pre-reset bit5", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_out("abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_out($sformatf("abort quiet%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // reset and load together: reset wins
    rst  = 1'b1;
    load = 1'b1;
    din  = 8'hFF;
    tick();
    rst  = 1'b0;
    load = 1'b0;
    chk_out("rst+load", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("rst+load after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst+load state", {6'b0, dbg_l}, 8'd0);

    // a normal transfer still works afterwards
    xfer("post-reset", 8'b01011010, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
